// File: rtl/spi_aes_slave_if.sv
// rtl/spi_aes_slave_if.sv - SPI pin and AES core handshake bundle for spi_aes_slave
//
// Purpose : groups the 4-wire SPI link and the AES core start/done interface
//           so that the slave and its environment share one port.
// Params  : Nk - key length in 32-bit words (4/6/8), KEY_W = Nk*32
// Signals : sclk, cs_n, mosi, miso        SPI link (mode 0, MSB first)
//           core_start, core_mode         launch pulse, 0=encrypt 1=decrypt
//           core_data, core_key           operands held stable until next start
//           core_done, core_result        completion and 128-bit result
// Modports: slave  - the spi_aes_slave side
//           master - SPI master plus AES core side (testbench / system)

interface spi_aes_slave_if #(
  parameter int Nk = 4
);
  localparam int KEY_W = Nk * 32;

  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic             core_start;
  logic             core_mode;
  logic [127:0]     core_data;
  logic [KEY_W-1:0] core_key;
  logic             core_done;
  logic [127:0]     core_result;

  modport slave (
    input  sclk, cs_n, mosi, core_done, core_result,
    output miso, core_start, core_mode, core_data, core_key
  );

  modport master (
    output sclk, cs_n, mosi, core_done, core_result,
    input  miso, core_start, core_mode, core_data, core_key
  );
endinterface

// File: rtl/spi_aes_slave.sv
// rtl/spi_aes_slave.sv - SPI slave endpoint launching AES encrypt/decrypt on the core
//
// Purpose : parses SPI frames (cmd byte, 128-bit block, KEY_W-bit key), starts
//           one AES operation per accepted write frame and serves the result
//           (cmd 0x03) or a status byte (cmd 0x04) back over MISO.
// Macro   : SPI_SLAVE_STATUS_EN - when defined, cmd 0x04 returns
//           {6'b0, busy, done_out}; otherwise 0x04 is an unknown command.
// Ports   : i_clk_slave  system clock, rising edge
//           i_rst        asynchronous active-low reset
//           bus          spi_aes_slave_if.slave (SPI pins + core handshake)
//           o_done_out   result available in o_data_out
//           o_data_out   last core result
//           o_frame_err  one-cycle pulse on a rejected frame

module spi_aes_slave #(
  parameter int Nk = 4
) (
  input  logic                  i_clk_slave,
  input  logic                  i_rst,
  spi_aes_slave_if.slave        bus,
  output logic                  o_done_out,
  output logic [127:0]          o_data_out,
  output logic                  o_frame_err
);
  localparam int KEY_W = Nk * 32;
  localparam int RX_W  = 128 + KEY_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_CMD,
    S_RX_DATA,
    S_RX_KEY,
    S_HOLD,
    S_TX
`ifdef SPI_SLAVE_STATUS_EN
    , S_TX_STAT
`endif
  } state_t;

  // [1:0] is the 2-flop synchronizer, [2] is the previous synchronized value
  logic [2:0]       r_sclk_sync;
  logic [2:0]       r_cs_sync;
  logic [1:0]       r_mosi_sync;

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_bit_cnt;
  logic [7:0]       r_cmd;
  logic [RX_W-1:0]  r_rx;
  logic             r_frame_ok;
  logic [127:0]     r_tx;
  logic             r_miso;
  logic             r_busy;
  logic             r_cs_rise_pend;
  logic             r_core_start;
  logic             r_core_mode;
  logic [127:0]     r_core_data;
  logic [KEY_W-1:0] r_core_key;
  logic             r_done_out;
  logic [127:0]     r_data_out;
  logic             r_frame_err;

  logic             w_sclk_rise;
  logic             w_sclk_fall;
  logic             w_cs_fall;
  logic             w_cs_rise;
  logic             w_cs_rise_eff;
  logic             w_mosi;
  logic             w_done_take;
  logic [7:0]       w_cmd_next;

  logic             w_cmd_shift;
  logic             w_rx_shift;
  logic             w_cnt_clr;
  logic             w_frame_clr;
  logic             w_frame_ok_set;
  logic             w_start;
  logic             w_err;
  logic             w_tx_load_data;
  logic             w_tx_load_stat;
  logic             w_tx_shift;
  logic             w_miso_clr;

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
  assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_mosi      = r_mosi_sync[1];
  assign w_cmd_next  = {r_cmd[6:0], w_mosi};

  // Ignore core_done in the start cycle so a level-type done left over from
  // the previous operation is not mistaken for completion of the new one.
  assign w_done_take = r_busy & bus.core_done & ~r_core_start;

  // core_done wins over a coincident cs_n rise: the rise is replayed one
  // cycle later, after busy has cleared.
  assign w_cs_rise_eff = (w_cs_rise & ~w_done_take) | r_cs_rise_pend;

  always_ff @(posedge i_clk_slave or negedge i_rst) begin
    if (!i_rst) begin
      r_sclk_sync <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_mosi_sync <= 2'b00;
      r_state     <= S_IDLE;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], bus.sclk};
      r_cs_sync   <= {r_cs_sync[1:0], bus.cs_n};
      r_mosi_sync <= {r_mosi_sync[0], bus.mosi};
      r_state     <= w_state_next;
    end
  end

  // Frame parser. A running core operation is tracked by r_busy rather than
  // a state, so frames keep being parsed while the core works.
  always_comb begin
    w_state_next   = r_state;
    w_cmd_shift    = 1'b0;
    w_rx_shift     = 1'b0;
    w_cnt_clr      = 1'b0;
    w_frame_clr    = 1'b0;
    w_frame_ok_set = 1'b0;
    w_start        = 1'b0;
    w_err          = 1'b0;
    w_tx_load_data = 1'b0;
    w_tx_load_stat = 1'b0;
    w_tx_shift     = 1'b0;
    w_miso_clr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_next = S_RX_CMD;
          w_cnt_clr    = 1'b1;
          w_frame_clr  = 1'b1;
        end
      end
      S_RX_CMD: begin
        if (w_cs_rise_eff) begin
          w_err        = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_sclk_rise) begin
          w_cmd_shift = 1'b1;
          if (r_bit_cnt == 8'd7) begin
            w_cnt_clr = 1'b1;
            case (w_cmd_next)
              8'h01, 8'h02: w_state_next = S_RX_DATA;
              8'h03: begin
                w_state_next   = S_TX;
                w_tx_load_data = 1'b1;
              end
`ifdef SPI_SLAVE_STATUS_EN
              8'h04: begin
                w_state_next   = S_TX_STAT;
                w_tx_load_stat = 1'b1;
              end
`endif
              default: w_state_next = S_HOLD;
            endcase
          end
        end
      end
      S_RX_DATA: begin
        if (w_cs_rise_eff) begin
          w_err        = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_sclk_rise) begin
          w_rx_shift = 1'b1;
          if (r_bit_cnt == 8'd127) begin
            w_cnt_clr    = 1'b1;
            w_state_next = S_RX_KEY;
          end
        end
      end
      S_RX_KEY: begin
        if (w_cs_rise_eff) begin
          w_err        = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_sclk_rise) begin
          w_rx_shift = 1'b1;
          if (r_bit_cnt == 8'(KEY_W - 1)) begin
            w_frame_ok_set = 1'b1;
            w_state_next   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_cs_rise_eff) begin
          w_state_next = S_IDLE;
          if (r_frame_ok && !r_busy) w_start = 1'b1;
          else                       w_err   = 1'b1;
        end
      end
      S_TX
`ifdef SPI_SLAVE_STATUS_EN
      , S_TX_STAT
`endif
      : begin
        if (w_cs_rise_eff) begin
          w_state_next = S_IDLE;
          w_miso_clr   = 1'b1;
        end else if (w_sclk_fall) begin
          w_tx_shift = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_slave or negedge i_rst) begin
    if (!i_rst) begin
      r_bit_cnt      <= '0;
      r_cmd          <= '0;
      r_rx           <= '0;
      r_frame_ok     <= 1'b0;
      r_tx           <= '0;
      r_miso         <= 1'b0;
      r_busy         <= 1'b0;
      r_cs_rise_pend <= 1'b0;
      r_core_start   <= 1'b0;
      r_core_mode    <= 1'b0;
      r_core_data    <= '0;
      r_core_key     <= '0;
      r_done_out     <= 1'b0;
      r_data_out     <= '0;
      r_frame_err    <= 1'b0;
    end else begin
      r_cs_rise_pend <= w_cs_rise & w_done_take;
      r_frame_err    <= w_err;
      r_core_start   <= w_start;

      if (w_cnt_clr)                     r_bit_cnt <= '0;
      else if (w_cmd_shift || w_rx_shift) r_bit_cnt <= r_bit_cnt + 8'd1;

      if (w_cmd_shift) r_cmd <= w_cmd_next;
      if (w_rx_shift)  r_rx  <= {r_rx[RX_W-2:0], w_mosi};

      if (w_frame_clr)         r_frame_ok <= 1'b0;
      else if (w_frame_ok_set) r_frame_ok <= 1'b1;

      // First falling edge after the cmd byte drives bit 127; zeros shift in
      // behind the payload so miso idles low after 128 bits.
      if (w_tx_load_data)      r_tx <= r_data_out;
      else if (w_tx_load_stat) r_tx <= {6'b0, r_busy, r_done_out, 120'b0};
      else if (w_tx_shift)     r_tx <= {r_tx[126:0], 1'b0};

      if (w_miso_clr)      r_miso <= 1'b0;
      else if (w_tx_shift) r_miso <= r_tx[127];

      if (w_start) begin
        r_busy      <= 1'b1;
        r_done_out  <= 1'b0;
        r_core_mode <= (r_cmd == 8'h02);
        r_core_data <= r_rx[RX_W-1:KEY_W];
        r_core_key  <= r_rx[KEY_W-1:0];
      end else if (w_done_take) begin
        r_busy     <= 1'b0;
        r_done_out <= 1'b1;
        r_data_out <= bus.core_result;
      end
    end
  end

  // Gate with the raw pin so miso is low as soon as cs_n is released.
  assign bus.miso       = r_miso & ~bus.cs_n;
  assign bus.core_start = r_core_start;
  assign bus.core_mode  = r_core_mode;
  assign bus.core_data  = r_core_data;
  assign bus.core_key   = r_core_key;
  assign o_done_out     = r_done_out;
  assign o_data_out     = r_data_out;
  assign o_frame_err    = r_frame_err;
endmodule

// File: tb/tb_spi_aes_slave.sv
// tb/tb_spi_aes_slave.sv - directed self-checking bench for spi_aes_slave

module tb_spi_aes_slave;
  localparam int Nk    = 4;
  localparam int KEY_W = Nk * 32;
  localparam int FW    = 8 + 128 + KEY_W;
  localparam logic [127:0]     PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0]     CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [KEY_W-1:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         done_out;
  logic [127:0] data_out;
  logic         frame_err;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int ferr_cnt = 0;
  int core_lat = 20;
  int core_cnt = -1;
  logic             m_mode;
  logic [127:0]     m_data;
  logic [KEY_W-1:0] m_key;

  spi_aes_slave_if #(.Nk(Nk)) bus ();

  spi_aes_slave #(.Nk(Nk)) dut (
    .i_clk_slave (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_done_out  (done_out),
    .o_data_out  (data_out),
    .o_frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // AES core stand-in: answers the known vectors after core_lat cycles.
  always @(negedge clk) begin
    bus.core_done = 1'b0;
    if (bus.core_start === 1'b1) begin
      start_cnt++;
      m_mode   = bus.core_mode;
      m_data   = bus.core_data;
      m_key    = bus.core_key;
      core_cnt = core_lat;
    end else if (core_cnt > 0) begin
      core_cnt--;
    end else if (core_cnt == 0) begin
      bus.core_done = 1'b1;
      if (!m_mode && m_data == PT && m_key == KEY)     bus.core_result = CT;
      else if (m_mode && m_data == CT && m_key == KEY) bus.core_result = PT;
      else                                             bus.core_result = '1;
      core_cnt = -1;
    end
    if (frame_err === 1'b1) ferr_cnt++;
  end

  task automatic spi_frame(input logic [FW-1:0] v, input int nbits, output logic [127:0] rx);
    rx = '0;
    bus.cs_n = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = v[FW-1-i];
      #50;
      if (i >= 8) rx = {rx[126:0], bus.miso};
      bus.sclk = 1'b1;
      #50;
      bus.sclk = 1'b0;
    end
    #100;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    #200;
  endtask

  task automatic wait_done(input int bound);
    for (int k = 0; k < bound && done_out !== 1'b1; k++) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", bus.miso); end
    checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b want 0", bus.core_start); end
    checks++; if (bus.core_mode !== 1'b0) begin errors++; $display("FAIL reset_core_mode: got %b want 0", bus.core_mode); end
    checks++; if (bus.core_data !== 128'h0) begin errors++; $display("FAIL reset_core_data: got %h want 0", bus.core_data); end
    checks++; if (bus.core_key !== '0) begin errors++; $display("FAIL reset_core_key: got %h want 0", bus.core_key); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done_out: got %b want 0", done_out); end
    checks++; if (data_out !== 128'h0) begin errors++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_encrypt;
    int s0 = start_cnt;
    int f0 = ferr_cnt;
    logic [127:0] rx;
    core_lat = 20;
    spi_frame({8'h01, PT, KEY}, FW, rx);
    wait_done(300);
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL enc_starts: got %0d want 1", start_cnt - s0); end
    checks++; if (bus.core_mode !== 1'b0) begin errors++; $display("FAIL enc_mode: got %b want 0", bus.core_mode); end
    checks++; if (bus.core_data !== PT) begin errors++; $display("FAIL enc_core_data: got %h want %h", bus.core_data, PT); end
    checks++; if (bus.core_key !== KEY) begin errors++; $display("FAIL enc_core_key: got %h want %h", bus.core_key, KEY); end
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL enc_done_out: got %b want 1", done_out); end
    checks++; if (data_out !== CT) begin errors++; $display("FAIL enc_data_out: got %h want %h", data_out, CT); end
    checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL enc_frame_err: got %0d pulses want 0", ferr_cnt - f0); end
  endtask

  task automatic test_read;
    logic [127:0] rx;
    spi_frame({8'h03, {(FW-8){1'b0}}}, 136, rx);
    checks++; if (rx !== CT) begin errors++; $display("FAIL read_miso: got %h want %h", rx, CT); end
    checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL read_miso_idle: got %b want 0", bus.miso); end
  endtask

  task automatic test_decrypt;
    int s0 = start_cnt;
    logic [127:0] rx;
    core_lat = 20;
    spi_frame({8'h02, CT, KEY}, FW, rx);
    wait_done(300);
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL dec_starts: got %0d want 1", start_cnt - s0); end
    checks++; if (bus.core_mode !== 1'b1) begin errors++; $display("FAIL dec_mode: got %b want 1", bus.core_mode); end
    checks++; if (bus.core_data !== CT) begin errors++; $display("FAIL dec_core_data: got %h want %h", bus.core_data, CT); end
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL dec_done_out: got %b want 1", done_out); end
    checks++; if (data_out !== PT) begin errors++; $display("FAIL dec_data_out: got %h want %h", data_out, PT); end
  endtask

  task automatic test_bad_frames;
    int s0 = start_cnt;
    int f0 = ferr_cnt;
    logic [127:0] rx;
    spi_frame({8'h01, PT, KEY}, 40, rx);
    checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL trunc_frame_err: got %0d pulses want 1", ferr_cnt - f0); end
    checks++; if (start_cnt != s0) begin errors++; $display("FAIL trunc_starts: got %0d want 0", start_cnt - s0); end
    checks++; if (data_out !== PT) begin errors++; $display("FAIL trunc_data_out: got %h want %h", data_out, PT); end
    spi_frame({8'h7F, PT, KEY}, 24, rx);
    checks++; if (ferr_cnt - f0 != 2) begin errors++; $display("FAIL badcmd_frame_err: got %0d pulses want 2", ferr_cnt - f0); end
    checks++; if (start_cnt != s0) begin errors++; $display("FAIL badcmd_starts: got %0d want 0", start_cnt - s0); end
    checks++; if (data_out !== PT) begin errors++; $display("FAIL badcmd_data_out: got %h want %h", data_out, PT); end
  endtask

  task automatic test_back_to_back;
    int s0 = start_cnt;
    int f0 = ferr_cnt;
    logic [127:0] rx;
    core_lat = 8000;
    spi_frame({8'h01, PT, KEY}, FW, rx);
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL busy_first_start: got %0d want 1", start_cnt - s0); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL busy_done_cleared: got %b want 0", done_out); end
    spi_frame({8'h03, {(FW-8){1'b0}}}, 136, rx);
    checks++; if (rx !== PT) begin errors++; $display("FAIL busy_read: got %h want %h", rx, PT); end
    spi_frame({8'h02, CT, KEY}, FW, rx);
    checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL busy_write_err: got %0d pulses want 1", ferr_cnt - f0); end
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL busy_no_restart: got %0d want 1", start_cnt - s0); end
    spi_frame({8'h04, {(FW-8){1'b0}}}, 16, rx);
`ifdef SPI_SLAVE_STATUS_EN
    checks++; if (rx[7:0] !== 8'h02) begin errors++; $display("FAIL status_busy: got %h want 02", rx[7:0]); end
`else
    checks++; if (ferr_cnt - f0 != 2) begin errors++; $display("FAIL cmd04_unknown: got %0d pulses want 2", ferr_cnt - f0); end
`endif
    wait_done(9000);
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL busy_done: got %b want 1", done_out); end
    checks++; if (data_out !== CT) begin errors++; $display("FAIL busy_data_out: got %h want %h", data_out, CT); end
`ifdef SPI_SLAVE_STATUS_EN
    spi_frame({8'h04, {(FW-8){1'b0}}}, 16, rx);
    checks++; if (rx[7:0] !== 8'h01) begin errors++; $display("FAIL status_done: got %h want 01", rx[7:0]); end
`endif
  endtask

  task automatic test_reset_run;
    int s0 = start_cnt;
    logic [127:0] rx;
    core_lat = 100;
    spi_frame({8'h01, PT, KEY}, FW, rx);
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL rrun_start: got %0d want 1", start_cnt - s0); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.core_data !== 128'h0) begin errors++; $display("FAIL rrun_core_data: got %h want 0", bus.core_data); end
    checks++; if (bus.core_key !== '0) begin errors++; $display("FAIL rrun_core_key: got %h want 0", bus.core_key); end
    checks++; if (data_out !== 128'h0) begin errors++; $display("FAIL rrun_data_out: got %h want 0", data_out); end
    rst = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL rrun_done_ignored: got %b want 0", done_out); end
    checks++; if (data_out !== 128'h0) begin errors++; $display("FAIL rrun_data_kept: got %h want 0", data_out); end
    core_lat = 20;
    spi_frame({8'h02, CT, KEY}, FW, rx);
    wait_done(300);
    checks++; if (start_cnt - s0 != 2) begin errors++; $display("FAIL rrun_restart: got %0d want 2", start_cnt - s0); end
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL rrun_next_done: got %b want 1", done_out); end
    checks++; if (data_out !== PT) begin errors++; $display("FAIL rrun_next_data: got %h want %h", data_out, PT); end
  endtask

  initial begin
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    test_reset;
    test_encrypt;
    test_read;
    test_decrypt;
    test_bad_frames;
    test_back_to_back;
    test_reset_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
